// File: rtl/c2h_packetizer.sv
// DDR read-beat to AXI-Stream packetizer for the C2H channel: a FIFO absorbs DMA stalls,
// a single output register frames packets of PKT_BEATS beats, closed early on flush or idle timeout.
module c2h_packetizer #(
  parameter int DATA_WIDTH    = 512,
  parameter int FIFO_DEPTH    = 64,
  parameter int PKT_BEATS     = 16,
  parameter int FLUSH_TIMEOUT = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  input  logic                          rd_valid,
  input  logic                          flush,
  output logic [DATA_WIDTH-1:0]         M_AXIS_C2H_tdata,
  output logic                          M_AXIS_C2H_tvalid,
  output logic [DATA_WIDTH/8-1:0]       M_AXIS_C2H_tkeep,
  output logic                          M_AXIS_C2H_tlast,
  input  logic                          M_AXIS_C2H_tready,
  input  logic                          ovf_clear,
  output logic                          overflow,
  output logic [15:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam int IW = $clog2(FLUSH_TIMEOUT) + 1;
  localparam int KW = DATA_WIDTH / 8;

  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);
  localparam logic [BW-1:0] BEAT_ONE   = BW'(1'b1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(PKT_BEATS - 1);
  localparam logic [IW-1:0] IDLE_ONE   = IW'(1'b1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(FLUSH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_CLOSING = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [BW-1:0]           beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]           idle_cnt_q, idle_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                    tlast_q, tlast_d;
  logic                    overflow_q, overflow_d;
  logic [15:0]             drop_count_q, drop_count_d;

  logic push, drop, out_free, at_boundary, has_one, load, load_last;
  logic close_pending;

  assign close_pending = (state_q == ST_CLOSING);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (push) state_d = ST_OPEN;
        else      state_d = ST_IDLE;
      end
      ST_OPEN: begin
        if (load && at_boundary && (count_d == '0))           state_d = ST_IDLE;
        else if (flush || (idle_cnt_q == IDLE_LIMIT))         state_d = ST_CLOSING;
        else                                                  state_d = ST_OPEN;
      end
      ST_CLOSING: begin
        // Once the closing tlast is out, leftover or newly written beats start a fresh packet.
        if (load && load_last) state_d = (count_d == '0) ? ST_IDLE : ST_OPEN;
        else                   state_d = ST_CLOSING;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idle_cnt_d = '0;
    if ((state_q == ST_OPEN) && (state_d == ST_OPEN)) begin
      if (rd_valid) idle_cnt_d = '0;
      else          idle_cnt_d = idle_cnt_q + IDLE_ONE;
    end else begin
      idle_cnt_d = '0;
    end
  end

  always_comb begin
    push        = rd_valid && (count_q < DEPTH_C);
    drop        = rd_valid && !push;
    out_free    = !out_valid_q || M_AXIS_C2H_tready;
    at_boundary = (beat_cnt_q == LAST_BEAT);
    has_one     = (count_q == CNT_ONE);
    // A lone beat is held back until its tlast is known, so tlast never changes while presented.
    load        = out_free && (count_q != '0) && (!has_one || at_boundary || close_pending);
    load_last   = at_boundary || (close_pending && has_one);

    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = load ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push, load})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    if (load) begin
      beat_cnt_d  = load_last ? '0 : (beat_cnt_q + BEAT_ONE);
      out_valid_d = 1'b1;
      tdata_d     = fifo_mem_q[rd_ptr_q];
      tlast_d     = load_last;
    end else if (out_valid_q && M_AXIS_C2H_tready) begin
      out_valid_d = 1'b0;
      tlast_d     = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (ovf_clear) begin
      overflow_d   = drop;
      drop_count_d = drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      overflow_d   = 1'b1;
      drop_count_d = (drop_count_q == 16'hFFFF) ? drop_count_q : (drop_count_q + 16'd1);
    end else begin
      overflow_d   = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= 16'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      beat_cnt_q   <= beat_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      out_valid_q  <= out_valid_d;
      tdata_q      <= tdata_d;
      tlast_q      <= tlast_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign M_AXIS_C2H_tdata  = tdata_q;
  assign M_AXIS_C2H_tvalid = out_valid_q;
  assign M_AXIS_C2H_tkeep  = {KW{out_valid_q}};
  assign M_AXIS_C2H_tlast  = tlast_q;
  assign overflow          = overflow_q;
  assign drop_count        = drop_count_q;
  assign fifo_level        = count_q;

endmodule

// File: tb/tb_c2h_packetizer.sv
// Randomized bench for c2h_packetizer: a queue-based packet model is checked against the DUT
// on every falling edge, plus literal expectations for the directed scenarios.
module tb_c2h_packetizer;
  localparam int DW    = 512;
  localparam int DEPTH = 64;
  localparam int PKT   = 16;
  localparam int TMO   = 256;
  localparam int KW    = DW / 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] rd_data;
  logic          rd_valid, flush, tready, ovf_clear;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, overflow;
  logic [KW-1:0] tkeep;
  logic [15:0]   drop_count;
  logic [LW-1:0] fifo_level;

  c2h_packetizer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PKT_BEATS(PKT), .FLUSH_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rd_data(rd_data), .rd_valid(rd_valid), .flush(flush),
    .M_AXIS_C2H_tdata(tdata), .M_AXIS_C2H_tvalid(tvalid), .M_AXIS_C2H_tkeep(tkeep),
    .M_AXIS_C2H_tlast(tlast), .M_AXIS_C2H_tready(tready), .ovf_clear(ovf_clear),
    .overflow(overflow), .drop_count(drop_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered beats in a queue, plus the presented beat and packet position.
  logic [DW-1:0] mq[$];
  bit            m_valid, m_last, m_closing, m_ovf;
  logic [DW-1:0] m_data;
  int            m_pos, m_idle, m_drops;

  task automatic model_reset();
    mq.delete();
    m_valid = 0; m_last = 0; m_closing = 0; m_ovf = 0;
    m_data = '0; m_pos = 0; m_idle = 0; m_drops = 0;
  endtask

  task automatic model_step();
    int cnt, cnt_n;
    bit push, drop, load, last, was_open, now_open, close_n;
    if (rst) begin
      model_reset();
      return;
    end
    cnt   = mq.size();
    push  = rd_valid && (cnt < DEPTH);
    drop  = rd_valid && !push;
    load  = (!m_valid || tready) && (cnt >= 1) && (cnt >= 2 || m_pos == PKT - 1 || m_closing);
    last  = (m_pos == PKT - 1) || (m_closing && cnt == 1);
    cnt_n = cnt + int'(push) - int'(load);
    was_open = (cnt > 0) && !m_closing;
    if (m_closing)     close_n = !(load && last);
    else if (was_open) close_n = !(load && last && cnt_n == 0) && (flush || m_idle == TMO - 1);
    else               close_n = 0;
    now_open  = (cnt_n > 0) && !close_n;
    m_idle    = (was_open && now_open) ? (rd_valid ? 0 : m_idle + 1) : 0;
    m_closing = close_n;
    if (load) begin
      m_data  = mq.pop_front();
      m_valid = 1;
      m_last  = last;
      m_pos   = last ? 0 : m_pos + 1;
    end else if (m_valid && tready) begin
      m_valid = 0;
    end
    if (push) mq.push_back(rd_data);
    if (ovf_clear) begin
      m_ovf   = drop;
      m_drops = drop ? 1 : 0;
    end else if (drop) begin
      m_ovf   = 1;
      m_drops = (m_drops == 65535) ? 65535 : m_drops + 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(posedge rst);
    model_reset();
  end

  // Per-cycle comparison against the model, and a handshake monitor for the directed checks.
  int            hs_cnt = 0, hs_last = 0;
  logic [DW-1:0] last_hs_data = '0;

  initial forever begin
    @(negedge clk);
    chk("tvalid", tvalid, m_valid);
    if (m_valid) begin
      chk("tdata", tdata, m_data);
      chk("tlast", tlast, m_last);
    end
    chk("tkeep", tkeep, m_valid ? {KW{1'b1}} : {KW{1'b0}});
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drops);
    chk("fifo_level", fifo_level, mq.size());
    if (!rst && tvalid && tready) begin
      hs_cnt++;
      if (tlast) hs_last++;
      last_hs_data = tdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_burst(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      rd_valid = 1'b1;
      rd_data  = DW'(base + i);
      tick();
    end
    rd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n;
    n = 0;
    while (n < maxc && !(fifo_level == '0 && !tvalid)) begin
      tick();
      n++;
    end
    chk(name, (fifo_level == '0 && !tvalid), 1'b1);
  endtask

  task automatic wait_hs(input int target, input int maxc);
    int n;
    n = 0;
    while (n < maxc && hs_cnt < target) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, l0, n, sent;
    model_reset();
    rst = 1'b1; rd_valid = 1'b0; rd_data = '0; flush = 1'b0; tready = 1'b0; ovf_clear = 1'b0;
    repeat (3) tick();
    chk("reset_tvalid", tvalid, 1'b0);
    chk("reset_tlast", tlast, 1'b0);
    chk("reset_tdata", tdata, '0);
    chk("reset_tkeep", tkeep, '0);
    chk("reset_level", fifo_level, '0);
    rst = 1'b0;
    tick();

    // Full 16-beat packet streamed straight through.
    tready = 1'b1;
    h0 = hs_cnt; l0 = hs_last;
    send_burst(16, 0);
    repeat (5) tick();
    chk("t1_beats", hs_cnt - h0, 16);
    chk("t1_tlasts", hs_last - l0, 1);
    chk("t1_last_data", last_hs_data, 15);

    // Short packet closed by the idle timeout.
    h0 = hs_cnt; l0 = hs_last;
    send_burst(5, 0);
    n = 0;
    while (n < 400 && !(tvalid && tlast)) begin
      tick();
      n++;
    end
    checks++;
    if (n < TMO || n > TMO + 2) begin
      failures++;
      $display("FAIL t2_timeout_latency actual=%0d required=%0d..%0d", n, TMO, TMO + 2);
    end
    chk("t2_early_beats", hs_cnt - h0, 4);
    chk("t2_last_data", tdata, 4);
    wait_idle("t2_idle", 20);

    // Flush-closed 3-beat packet followed by a fresh full packet.
    h0 = hs_cnt; l0 = hs_last;
    send_burst(3, 20);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    wait_idle("t3_idle", 20);
    chk("t3_beats", hs_cnt - h0, 3);
    chk("t3_tlasts", hs_last - l0, 1);
    chk("t3_last_data", last_hs_data, 22);
    h0 = hs_cnt; l0 = hs_last;
    send_burst(16, 40);
    wait_idle("t3b_idle", 20);
    chk("t3b_beats", hs_cnt - h0, 16);
    chk("t3b_tlasts", hs_last - l0, 1);

    // Overflow with the DMA stalled, then drain and clear.
    tready = 1'b0;
    send_burst(70, 100);
    tick(); tick();
    chk("t4_level", fifo_level, 64);
    chk("t4_drops", drop_count, 5);
    chk("t4_ovf", overflow, 1'b1);
    chk("t4_held", tvalid, 1'b1);
    h0 = hs_cnt; l0 = hs_last;
    tready = 1'b1;
    wait_hs(h0 + 65, 400);
    chk("t4_beats", hs_cnt - h0, 65);
    chk("t4_tlasts", hs_last - l0, 5);
    chk("t4_last_data", last_hs_data, 164);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0; tick();
    chk("t4_clr_ovf", overflow, 1'b0);
    chk("t4_clr_drops", drop_count, 0);

    // Clear arriving together with a drop: the drop wins.
    tready = 1'b0;
    send_burst(66, 300);
    rd_valid = 1'b1; rd_data = '1; ovf_clear = 1'b1;
    tick();
    rd_valid = 1'b0; ovf_clear = 1'b0;
    chk("t4b_drops", drop_count, 1);
    chk("t4b_ovf", overflow, 1'b1);
    tready = 1'b1;
    wait_idle("t4b_idle", 400);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;

    // Random backpressure, sparse input, no drops expected.
    h0 = hs_cnt; l0 = hs_last; sent = 0;
    for (int c = 0; c < 5000 && sent < 200; c++) begin
      tready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        rd_valid = 1'b1; rd_data = rand_data(); sent++;
      end else begin
        rd_valid = 1'b0;
      end
      tick();
    end
    rd_valid = 1'b0; tready = 1'b1;
    wait_idle("t5_idle", 400);
    chk("t5_beats", hs_cnt - h0, 200);
    chk("t5_tlasts", hs_last - l0, 13);
    chk("t5_drops", drop_count, 0);

    // Random traffic with random flush pulses; the model alone judges this phase.
    for (int c = 0; c < 400; c++) begin
      tready   = 1'($urandom_range(0, 1));
      rd_valid = 1'($urandom_range(0, 1));
      rd_data  = rand_data();
      flush    = ($urandom_range(0, 15) == 0);
      tick();
    end
    rd_valid = 1'b0; flush = 1'b0; tready = 1'b1;
    wait_idle("t5b_idle", 400);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;

    // Asynchronous reset in the middle of a packet.
    tready = 1'b0;
    send_burst(5, 700);
    tick();
    chk("t6_pre_tvalid", tvalid, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", tvalid, 1'b0);
    chk("t6_rst_level", fifo_level, '0);
    tick();
    rst = 1'b0;
    tready = 1'b1;
    tick();
    h0 = hs_cnt; l0 = hs_last;
    send_burst(16, 500);
    wait_idle("t6_idle", 20);
    chk("t6_beats", hs_cnt - h0, 16);
    chk("t6_tlasts", hs_last - l0, 1);
    chk("t6_last_data", last_hs_data, 515);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
